// File: rtl/k_and_s_pkg.sv
// -----------------------------------------------------------------------------
// k_and_s_pkg
//   Shared types for the K&S CPU: the decoded opcode that data_path presents
//   to control_unit. Encoded in 5 bits so that codes outside the ISA exist
//   and are treated as NOP by the controller.
// -----------------------------------------------------------------------------
package k_and_s_pkg;

    typedef enum logic [4:0] {
        I_NOP    = 5'd0,
        I_LOAD   = 5'd1,
        I_STORE  = 5'd2,
        I_MOVE   = 5'd3,
        I_ADD    = 5'd4,
        I_SUB    = 5'd5,
        I_AND    = 5'd6,
        I_OR     = 5'd7,
        I_BRANCH = 5'd8,
        I_BZERO  = 5'd9,
        I_BNZERO = 5'd10,
        I_BNEG   = 5'd11,
        I_BNNEG  = 5'd12,
        I_BOV    = 5'd13,
        I_BNOV   = 5'd14,
        I_HALT   = 5'd15
    } decoded_instruction_type;

endpackage

// File: rtl/control_unit.sv
// -----------------------------------------------------------------------------
// control_unit
//   Moore FSM sequencing fetch / decode / execute for the K&S CPU. Drives the
//   data_path control inputs and the RAM write strobe; reads back the decoded
//   opcode and the registered ALU flags.
//
//   Ports
//     clk, rst_n            clock (posedge) and async active-low reset
//     decoded_instruction   current IR opcode
//     zero_op, neg_op       registered zero / negative flags
//     unsigned_overflow     registered unsigned-overflow flag (no branch uses it)
//     signed_overflow       registered signed-overflow flag
//     branch                PC load select: 1 = mem_addr, 0 = PC+1
//     pc_enable             PC update strobe
//     ir_enable             IR load strobe
//     addr_sel              ram_addr select: 1 = mem_addr, 0 = PC
//     c_sel                 bus_c select: 1 = ALU, 0 = data_in
//     operation             ALU op: 00 OR, 01 ADD, 10 SUB, 11 AND
//     write_reg_enable      register-file write strobe
//     flags_reg_enable      flag-register update strobe
//     ram_write_enable      RAM write strobe
//     halt                  high while halted
//
//   MEM_RD_LAT: RAM read latency in cycles, legal 0..3.
//
//   state  | meaning
//   -------+--------------------------------------------------------------
//   START  | first cycle after reset, everything idle
//   FETCH  | PC on ram_addr for MEM_RD_LAT+1 cycles, IR loads in the last
//   DECODE | IR stable, flags sampled, execute path chosen
//   LOAD   | mem_addr on ram_addr, register write in the last cycle
//   STORE  | operand onto data_out, RAM write in the second cycle
//   ALU    | one-cycle ALU op (or MOVE) into the register file
//   TAKE   | PC <= mem_addr
//   NEXT   | PC <= PC+1
//   HALT   | terminal, only reset leaves
// -----------------------------------------------------------------------------
module control_unit
    import k_and_s_pkg::*;
#(
    parameter int MEM_RD_LAT = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  decoded_instruction_type decoded_instruction,
    input  logic                    zero_op,
    input  logic                    neg_op,
    input  logic                    unsigned_overflow,
    input  logic                    signed_overflow,
    output logic                    branch,
    output logic                    pc_enable,
    output logic                    ir_enable,
    output logic                    addr_sel,
    output logic                    c_sel,
    output logic [1:0]              operation,
    output logic                    write_reg_enable,
    output logic                    flags_reg_enable,
    output logic                    ram_write_enable,
    output logic                    halt
);

    typedef enum logic [3:0] {
        S_START,
        S_FETCH,
        S_DECODE,
        S_LOAD,
        S_STORE,
        S_ALU,
        S_TAKE,
        S_NEXT,
        S_HALT
    } state_t;

    localparam logic [1:0] RD_LAST = 2'(MEM_RD_LAT);

    state_t     state;
    state_t     next_state;
    logic [1:0] wait_cnt;
    logic [1:0] next_wait_cnt;
    logic       rd_last;
    logic       cond_true;

    // No K&S branch tests the unsigned-overflow flag.
    logic unused_flag;
    assign unused_flag = unsigned_overflow;

    assign rd_last = (wait_cnt == RD_LAST);

    // Counter restarts on every state change; HALT never needs it.
    assign next_wait_cnt = ((next_state != state) || (state == S_HALT)) ? 2'd0
                                                                        : wait_cnt + 2'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_START;
            wait_cnt <= 2'd0;
        end else begin
            state    <= next_state;
            wait_cnt <= next_wait_cnt;
        end
    end

    always_comb begin
        cond_true = 1'b0;
        case (decoded_instruction)
            I_BRANCH: cond_true = 1'b1;
            I_BZERO:  cond_true = zero_op;
            I_BNZERO: cond_true = !zero_op;
            I_BNEG:   cond_true = neg_op;
            I_BNNEG:  cond_true = !neg_op;
            I_BOV:    cond_true = signed_overflow;
            I_BNOV:   cond_true = !signed_overflow;
            default:  cond_true = 1'b0;
        endcase
    end

    always_comb begin
        next_state       = state;
        branch           = 1'b0;
        pc_enable        = 1'b0;
        ir_enable        = 1'b0;
        addr_sel         = 1'b0;
        c_sel            = 1'b0;
        operation        = 2'b00;
        write_reg_enable = 1'b0;
        flags_reg_enable = 1'b0;
        ram_write_enable = 1'b0;
        halt             = 1'b0;

        case (state)
            S_START: begin
                next_state = S_FETCH;
            end

            S_FETCH: begin
                if (rd_last) begin
                    ir_enable  = 1'b1;
                    next_state = S_DECODE;
                end
            end

            S_DECODE: begin
                case (decoded_instruction)
                    I_LOAD:  next_state = S_LOAD;
                    I_STORE: next_state = S_STORE;
                    I_MOVE, I_ADD, I_SUB, I_AND, I_OR:
                             next_state = S_ALU;
                    I_HALT:  next_state = S_HALT;
                    I_BRANCH, I_BZERO, I_BNZERO, I_BNEG, I_BNNEG, I_BOV, I_BNOV:
                             next_state = cond_true ? S_TAKE : S_NEXT;
                    default: next_state = S_NEXT;
                endcase
            end

            S_LOAD: begin
                addr_sel = 1'b1;
                if (rd_last) begin
                    write_reg_enable = 1'b1;
                    next_state       = S_NEXT;
                end
            end

            S_STORE: begin
                addr_sel = 1'b1;
                if (wait_cnt == 2'd1) begin
                    ram_write_enable = 1'b1;
                    next_state       = S_NEXT;
                end
            end

            S_ALU: begin
                c_sel            = 1'b1;
                write_reg_enable = 1'b1;
                next_state       = S_NEXT;
                case (decoded_instruction)
                    I_ADD: begin
                        operation        = 2'b01;
                        flags_reg_enable = 1'b1;
                    end
                    I_SUB: begin
                        operation        = 2'b10;
                        flags_reg_enable = 1'b1;
                    end
                    I_AND: begin
                        operation        = 2'b11;
                        flags_reg_enable = 1'b1;
                    end
                    I_OR: begin
                        operation        = 2'b00;
                        flags_reg_enable = 1'b1;
                    end
                    // MOVE: a|a passes rA through unchanged, flags untouched.
                    default: operation = 2'b00;
                endcase
            end

            S_TAKE: begin
                addr_sel   = 1'b1;
                branch     = 1'b1;
                pc_enable  = 1'b1;
                next_state = S_FETCH;
            end

            S_NEXT: begin
                pc_enable  = 1'b1;
                next_state = S_FETCH;
            end

            S_HALT: begin
                halt = 1'b1;
            end

            default: begin
                next_state = S_START;
            end
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// -----------------------------------------------------------------------------
// tb_control_unit
//   Two controllers (read latency 1 and 3) share clock, reset and inputs.
//   Expected output streams come from an instruction-level model that lists,
//   per instruction, the outputs of each cycle from FETCH entry onward.
//   Output vector: {halt, branch, pc_en, ir_en, addr_sel, c_sel, op[1:0],
//                   wr_reg, wr_flags, wr_ram}
// -----------------------------------------------------------------------------
module tb_control_unit;
    import k_and_s_pkg::*;

    localparam logic [10:0] M_HALT = 11'h400;
    localparam logic [10:0] M_BR   = 11'h200;
    localparam logic [10:0] M_PC   = 11'h100;
    localparam logic [10:0] M_IR   = 11'h080;
    localparam logic [10:0] M_AS   = 11'h040;
    localparam logic [10:0] M_CS   = 11'h020;
    localparam logic [10:0] M_WR   = 11'h004;
    localparam logic [10:0] M_FR   = 11'h002;
    localparam logic [10:0] M_RW   = 11'h001;

    logic clk;
    logic rst_n;
    decoded_instruction_type decoded_instruction;
    logic zero_op, neg_op, unsigned_overflow, signed_overflow;

    logic       a_branch, a_pc, a_ir, a_as, a_cs, a_wr, a_fr, a_rw, a_halt;
    logic [1:0] a_op;
    logic       b_branch, b_pc, b_ir, b_as, b_cs, b_wr, b_fr, b_rw, b_halt;
    logic [1:0] b_op;
    logic [10:0] vec1, vec3;

    int checks = 0;
    int errors = 0;
    logic [10:0] exp_q[$];

    control_unit #(.MEM_RD_LAT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .decoded_instruction(decoded_instruction),
        .zero_op(zero_op), .neg_op(neg_op), .unsigned_overflow(unsigned_overflow),
        .signed_overflow(signed_overflow), .branch(a_branch), .pc_enable(a_pc),
        .ir_enable(a_ir), .addr_sel(a_as), .c_sel(a_cs), .operation(a_op),
        .write_reg_enable(a_wr), .flags_reg_enable(a_fr), .ram_write_enable(a_rw),
        .halt(a_halt)
    );

    control_unit #(.MEM_RD_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .decoded_instruction(decoded_instruction),
        .zero_op(zero_op), .neg_op(neg_op), .unsigned_overflow(unsigned_overflow),
        .signed_overflow(signed_overflow), .branch(b_branch), .pc_enable(b_pc),
        .ir_enable(b_ir), .addr_sel(b_as), .c_sel(b_cs), .operation(b_op),
        .write_reg_enable(b_wr), .flags_reg_enable(b_fr), .ram_write_enable(b_rw),
        .halt(b_halt)
    );

    assign vec1 = {a_halt, a_branch, a_pc, a_ir, a_as, a_cs, a_op, a_wr, a_fr, a_rw};
    assign vec3 = {b_halt, b_branch, b_pc, b_ir, b_as, b_cs, b_op, b_wr, b_fr, b_rw};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Instruction-level reference: cycle-by-cycle outputs from FETCH entry.
    function automatic void build(input decoded_instruction_type ins, input bit z,
                                  input bit n, input bit so, input int lat,
                                  input int halt_len);
        bit taken;
        exp_q.delete();
        for (int i = 0; i <= lat; i++) exp_q.push_back((i == lat) ? M_IR : 11'd0);
        exp_q.push_back(11'd0);
        case (ins)
            I_LOAD: begin
                for (int i = 0; i <= lat; i++)
                    exp_q.push_back(M_AS | ((i == lat) ? M_WR : 11'd0));
                exp_q.push_back(M_PC);
            end
            I_STORE: begin
                exp_q.push_back(M_AS);
                exp_q.push_back(M_AS | M_RW);
                exp_q.push_back(M_PC);
            end
            I_ADD:  begin exp_q.push_back(M_CS | M_WR | M_FR | 11'h008); exp_q.push_back(M_PC); end
            I_SUB:  begin exp_q.push_back(M_CS | M_WR | M_FR | 11'h010); exp_q.push_back(M_PC); end
            I_AND:  begin exp_q.push_back(M_CS | M_WR | M_FR | 11'h018); exp_q.push_back(M_PC); end
            I_OR:   begin exp_q.push_back(M_CS | M_WR | M_FR);           exp_q.push_back(M_PC); end
            I_MOVE: begin exp_q.push_back(M_CS | M_WR);                  exp_q.push_back(M_PC); end
            I_HALT: begin
                for (int i = 0; i < halt_len; i++) exp_q.push_back(M_HALT);
            end
            default: begin
                case (ins)
                    I_BRANCH: taken = 1'b1;
                    I_BZERO:  taken = z;
                    I_BNZERO: taken = !z;
                    I_BNEG:   taken = n;
                    I_BNNEG:  taken = !n;
                    I_BOV:    taken = so;
                    I_BNOV:   taken = !so;
                    default:  taken = 1'b0;
                endcase
                exp_q.push_back(taken ? (M_AS | M_BR | M_PC) : M_PC);
            end
        endcase
    endfunction

    task automatic apply(input decoded_instruction_type ins, input bit z, input bit n,
                         input bit uo, input bit so);
        decoded_instruction = ins;
        zero_op             = z;
        neg_op              = n;
        unsigned_overflow   = uo;
        signed_overflow     = so;
    endtask

    task automatic step(input bit sel, output logic [10:0] obs);
        @(posedge clk);
        #2;
        obs = sel ? vec3 : vec1;
    endtask

    // Leaves both controllers in START, 2 time units after a clock edge.
    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply(I_ADD, 1'b1, 1'b1, 1'b1, 1'b1);
        rst_n = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #2;
            checks++;
            if (vec1 !== 11'd0 || vec3 !== 11'd0) begin
                errors++;
                $display("FAIL reset_hold c=%0d got lat1=%b lat3=%b exp=0", c, vec1, vec3);
            end
            @(posedge clk);
        end
    endtask

    task automatic test_reset_release();
        logic [10:0] obs;
        do_reset();
        apply(I_NOP, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (vec1 !== 11'd0) begin
            errors++;
            $display("FAIL start_state got=%b exp=0", vec1);
        end
        build(I_NOP, 1'b0, 1'b0, 1'b0, 1, 0);
        foreach (exp_q[j]) begin
            step(1'b0, obs);
            checks++;
            if (obs !== exp_q[j]) begin
                errors++;
                $display("FAIL release_nop cyc=%0d got=%b exp=%b", j, obs, exp_q[j]);
            end
        end
    endtask

    task automatic test_alu_ops();
        decoded_instruction_type prog[6] = '{I_ADD, I_SUB, I_AND, I_OR, I_MOVE, I_ADD};
        logic [10:0] obs;
        do_reset();
        foreach (prog[k]) begin
            apply(prog[k], 1'(k), 1'(k >> 1), 1'b0, 1'b1);
            build(prog[k], 1'(k), 1'(k >> 1), 1'b1, 1, 0);
            foreach (exp_q[j]) begin
                step(1'b0, obs);
                checks++;
                if (obs !== exp_q[j]) begin
                    errors++;
                    $display("FAIL alu %s cyc=%0d got=%b exp=%b", prog[k].name(), j, obs, exp_q[j]);
                end
            end
        end
    endtask

    task automatic test_branches();
        decoded_instruction_type prog[12] = '{I_BZERO, I_BZERO, I_BNZERO, I_BNZERO,
                                              I_BNEG, I_BNNEG, I_BOV, I_BNOV, I_BOV,
                                              I_BRANCH, I_NOP, decoded_instruction_type'(5'd23)};
        logic [2:0] flg[12] = '{3'b100, 3'b000, 3'b000, 3'b100, 3'b010, 3'b010,
                                3'b001, 3'b001, 3'b110, 3'b000, 3'b111, 3'b111};
        logic [10:0] obs;
        do_reset();
        foreach (prog[k]) begin
            apply(prog[k], flg[k][2], flg[k][1], 1'b1, flg[k][0]);
            build(prog[k], flg[k][2], flg[k][1], flg[k][0], 1, 0);
            foreach (exp_q[j]) begin
                step(1'b0, obs);
                checks++;
                if (obs !== exp_q[j]) begin
                    errors++;
                    $display("FAIL branch k=%0d cyc=%0d got=%b exp=%b", k, j, obs, exp_q[j]);
                end
            end
        end
    endtask

    task automatic test_load_store_lat3();
        decoded_instruction_type prog[4] = '{I_LOAD, I_STORE, I_MOVE, I_LOAD};
        logic [10:0] obs;
        do_reset();
        foreach (prog[k]) begin
            apply(prog[k], 1'b0, 1'b0, 1'b0, 1'b0);
            build(prog[k], 1'b0, 1'b0, 1'b0, 3, 0);
            foreach (exp_q[j]) begin
                step(1'b1, obs);
                checks++;
                if (obs !== exp_q[j]) begin
                    errors++;
                    $display("FAIL lat3 %s cyc=%0d got=%b exp=%b", prog[k].name(), j, obs, exp_q[j]);
                end
            end
        end
    endtask

    task automatic test_random(input bit sel, input int lat, input int count);
        decoded_instruction_type ins;
        bit z, n, uo, so;
        int r;
        logic [10:0] obs;
        do_reset();
        for (int k = 0; k < count; k++) begin
            r = $urandom_range(0, 30);
            if (r >= 15) r++;
            ins = decoded_instruction_type'(5'(r));
            z = 1'($urandom); n = 1'($urandom); uo = 1'($urandom); so = 1'($urandom);
            apply(ins, z, n, uo, so);
            build(ins, z, n, so, lat, 0);
            foreach (exp_q[j]) begin
                step(sel, obs);
                checks++;
                if (obs !== exp_q[j]) begin
                    errors++;
                    $display("FAIL random lat=%0d k=%0d op=%0d cyc=%0d got=%b exp=%b",
                             lat, k, r, j, obs, exp_q[j]);
                end
            end
        end
    endtask

    task automatic test_halt();
        logic [10:0] obs;
        do_reset();
        apply(I_HALT, 1'b0, 1'b0, 1'b0, 1'b0);
        build(I_HALT, 1'b0, 1'b0, 1'b0, 1, 100);
        foreach (exp_q[j]) begin
            if (j == 10) apply(I_BRANCH, 1'b1, 1'b1, 1'b1, 1'b1);
            step(1'b0, obs);
            checks++;
            if (obs !== exp_q[j]) begin
                errors++;
                $display("FAIL halt cyc=%0d got=%b exp=%b", j, obs, exp_q[j]);
            end
        end
    endtask

    task automatic test_reset_mid_load();
        logic [10:0] obs;
        do_reset();
        apply(I_LOAD, 1'b0, 1'b0, 1'b0, 1'b0);
        build(I_LOAD, 1'b0, 1'b0, 1'b0, 3, 0);
        for (int j = 0; j < 7; j++) begin
            step(1'b1, obs);
            checks++;
            if (obs !== exp_q[j]) begin
                errors++;
                $display("FAIL midload_pre cyc=%0d got=%b exp=%b", j, obs, exp_q[j]);
            end
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (vec3 !== 11'd0 || vec1 !== 11'd0) begin
            errors++;
            $display("FAIL midload_async got lat3=%b lat1=%b exp=0", vec3, vec1);
        end
        step(1'b1, obs);
        checks++;
        if (obs !== 11'd0) begin
            errors++;
            $display("FAIL midload_held got=%b exp=0", obs);
        end
        rst_n = 1'b1;
        checks++;
        if (vec3 !== 11'd0) begin
            errors++;
            $display("FAIL midload_start got=%b exp=0", vec3);
        end
        apply(I_NOP, 1'b0, 1'b0, 1'b0, 1'b0);
        build(I_NOP, 1'b0, 1'b0, 1'b0, 3, 0);
        foreach (exp_q[j]) begin
            step(1'b1, obs);
            checks++;
            if (obs !== exp_q[j]) begin
                errors++;
                $display("FAIL midload_refetch cyc=%0d got=%b exp=%b", j, obs, exp_q[j]);
            end
        end
    endtask

    task automatic test_reset_mid_store();
        logic [10:0] obs;
        do_reset();
        apply(I_STORE, 1'b0, 1'b0, 1'b0, 1'b0);
        build(I_STORE, 1'b0, 1'b0, 1'b0, 1, 0);
        for (int j = 0; j < 5; j++) begin
            step(1'b0, obs);
            checks++;
            if (obs !== exp_q[j]) begin
                errors++;
                $display("FAIL midstore_pre cyc=%0d got=%b exp=%b", j, obs, exp_q[j]);
            end
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (a_rw !== 1'b0 || vec1 !== 11'd0) begin
            errors++;
            $display("FAIL midstore_drop got=%b exp=0", vec1);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        apply(I_NOP, 1'b0, 1'b0, 1'b0, 1'b0);
        test_reset();
        test_reset_release();
        test_alu_ops();
        test_branches();
        test_load_store_lat3();
        test_random(1'b0, 1, 40);
        test_random(1'b1, 3, 40);
        test_halt();
        test_reset_mid_load();
        test_reset_mid_store();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
